// File: rtl/fsm_seq_pkg.sv
// Shared types for the run sequencer and its downstream timer.
package fsm_seq_pkg;

    localparam int TMR_N_DEFAULT = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_CLEAR,
        S_FINISH,
        S_FAULT
    } seq_state_t;

    typedef struct packed {
        logic tmr_start;
        logic tmr_clear;
        logic busy;
        logic done;
        logic err;
    } seq_out_t;

    // Moore output decode, applied to the state being entered so outputs are registered
    function automatic seq_out_t seq_outs(input seq_state_t s);
        seq_out_t o;
        o = '0;
        case (s)
            S_ARM:    begin o.tmr_start = 1'b1; o.busy = 1'b1; end
            S_WAIT:   o.busy = 1'b1;
            S_CLEAR:  begin o.tmr_clear = 1'b1; o.busy = 1'b1; end
            S_FINISH: begin o.done = 1'b1; o.busy = 1'b1; end
            S_FAULT:  begin o.err = 1'b1; o.tmr_clear = 1'b1; o.busy = 1'b1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fsm_timer.sv
// One-shot period timer: START begins a run, READY rises N-1 cycles later and holds until cleared.
module fsm_timer
    import fsm_seq_pkg::*;
#(
    parameter int N = TMR_N_DEFAULT
) (
    input  logic CLK,
    input  logic N_RESET,
    input  logic RESET,
    input  logic START,
    output logic READY
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;
    logic          run;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (RESET) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (START) begin
            cnt <= CW'(1);
            run <= 1'b1;
        end else if (run && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign READY = run && (cnt == LAST);

endmodule

// File: rtl/fsm_sequencer.sv
// Runs the downstream timer CYCLES times back to back, with abort, watchdog fault and run count.
module fsm_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int N       = TMR_N_DEFAULT,
    parameter int RUNS_W  = 4,
    parameter int TIMEOUT = N + 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              GO,
    input  logic [RUNS_W-1:0] CYCLES,
    input  logic              ABORT,
    input  logic              CLR_ERR,
    input  logic              TMR_READY,
    output logic              TMR_START,
    output logic              TMR_CLEAR,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [RUNS_W-1:0] RUNS
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    seq_state_t        state;
    seq_out_t          outs;
    logic [RUNS_W-1:0] target;
    logic              abort_f;
    logic [WC_W-1:0]   wcnt;
    logic [RUNS_W:0]   runs_nx;

    // extra bit catches the all-ones case so the count saturates instead of wrapping
    assign runs_nx = {1'b0, RUNS} + (RUNS_W + 1)'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            outs    <= '0;
            RUNS    <= '0;
            target  <= '0;
            abort_f <= 1'b0;
            wcnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (GO) begin
                    RUNS    <= '0;
                    abort_f <= 1'b0;
                    if (CYCLES != '0) begin
                        target <= CYCLES;
                        state  <= S_ARM;
                        outs   <= seq_outs(S_ARM);
                    end else begin
                        state <= S_FINISH;
                        outs  <= seq_outs(S_FINISH);
                    end
                end
                S_ARM: begin
                    if (ABORT) abort_f <= 1'b1;
                    wcnt  <= '0;
                    state <= S_WAIT;
                    outs  <= seq_outs(S_WAIT);
                end
                S_WAIT: begin
                    if (ABORT) abort_f <= 1'b1;
                    wcnt <= wcnt + WC_W'(1);
                    if (TMR_READY) begin
                        state <= S_CLEAR;
                        outs  <= seq_outs(S_CLEAR);
                    end else if (wcnt == WC_LAST) begin
                        state <= S_FAULT;
                        outs  <= seq_outs(S_FAULT);
                    end
                end
                S_CLEAR: begin
                    if (!runs_nx[RUNS_W]) RUNS <= runs_nx[RUNS_W-1:0];
                    if (runs_nx == {1'b0, target} || abort_f) begin
                        state <= S_FINISH;
                        outs  <= seq_outs(S_FINISH);
                    end else begin
                        state <= S_ARM;
                        outs  <= seq_outs(S_ARM);
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    outs  <= seq_outs(S_IDLE);
                end
                S_FAULT: if (CLR_ERR) begin
                    state <= S_IDLE;
                    outs  <= seq_outs(S_IDLE);
                end
                default: begin
                    state <= S_IDLE;
                    outs  <= seq_outs(S_IDLE);
                end
            endcase
        end
    end

    assign TMR_START = outs.tmr_start;
    assign TMR_CLEAR = outs.tmr_clear;
    assign BUSY      = outs.busy;
    assign DONE      = outs.done;
    assign ERR       = outs.err;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Sequencer driving a real fsm_timer: table of jobs plus fault and mid-job reset sequences.
module tb_fsm_sequencer;
    import fsm_seq_pkg::*;

    localparam int N       = 8;
    localparam int RUNS_W  = 4;
    localparam int TIMEOUT = N + 8;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              GO, ABORT, CLR_ERR;
    logic [RUNS_W-1:0] CYCLES;
    logic              tmr_ready, tmr_rdy_raw, ready_low, tmr_nrst;
    logic              TMR_START, TMR_CLEAR, BUSY, DONE, ERR;
    logic [RUNS_W-1:0] RUNS;

    int checks = 0;
    int failures = 0;

    typedef struct { int done_cyc; int runs; int starts; } exp_t;
    typedef struct { int cyc; int abort_run; } vec_t;

    exp_t sbq[$];
    vec_t vecs[6];

    always #5 CLK = ~CLK;

    assign tmr_ready = tmr_rdy_raw & ~ready_low;

    fsm_sequencer #(.N(N), .RUNS_W(RUNS_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .GO(GO), .CYCLES(CYCLES), .ABORT(ABORT),
        .CLR_ERR(CLR_ERR), .TMR_READY(tmr_ready), .TMR_START(TMR_START),
        .TMR_CLEAR(TMR_CLEAR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RUNS(RUNS)
    );

    fsm_timer #(.N(N)) tmr (
        .CLK(CLK), .N_RESET(tmr_nrst), .RESET(TMR_CLEAR), .START(TMR_START), .READY(tmr_rdy_raw)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outs(input string nm);
        chk({nm, "_outs"}, {TMR_START, TMR_CLEAR, BUSY, DONE, ERR}, 0);
    endtask

    task automatic start_go(input int cyc);
        @(negedge CLK);
        GO = 1'b1;
        CYCLES = cyc[RUNS_W-1:0];
        @(posedge CLK);
        @(negedge CLK);   // sample point of cycle 0 after the accept edge
        GO = 1'b0;
    endtask

    task automatic job(input int cyc, input int ab);
        exp_t e, g;
        int starts, last;
        bit seen;
        e.runs = (ab != 0 && ab < cyc) ? ab : cyc;
        e.starts = e.runs;
        e.done_cyc = e.runs * (N + 1);
        sbq.push_back(e);
        start_go(cyc);
        starts = 0; last = 0; seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (k > 0) @(negedge CLK);
            if (TMR_START) begin
                chk("start_time", k, starts * (N + 1));
                starts++;
                last = k;
            end
            ABORT = (ab != 0 && starts == ab && k == last + 3);
            if (DONE) begin
                seen = 1'b1;
                g = sbq.pop_front();
                chk("done_cycle", k, g.done_cyc);
                chk("runs_at_done", int'(RUNS), g.runs);
                chk("start_count", starts, g.starts);
            end
        end
        ABORT = 1'b0;
        if (!seen) begin
            chk("done_timeout", 0, 1);
            if (sbq.size() > 0) g = sbq.pop_front();
        end
        @(negedge CLK);
        chk("done_one_wide", int'(DONE), 0);
        chk("busy_after_done", int'(BUSY), 0);
        repeat (3) @(negedge CLK);
        chk("runs_hold_idle", int'(RUNS), e.runs);
    endtask

    initial begin
        exp_t e, g;
        int starts, last;
        bit seen;
        vecs[0] = '{3, 0};
        vecs[1] = '{0, 0};
        vecs[2] = '{5, 2};
        vecs[3] = '{15, 0};
        vecs[4] = '{1, 0};
        vecs[5] = '{2, 1};

        RESET = 1'b1; tmr_nrst = 1'b0; GO = 1'b0; ABORT = 1'b0; CLR_ERR = 1'b0;
        CYCLES = '0; ready_low = 1'b0;
        repeat (2) @(negedge CLK);
        chk_idle_outs("reset");
        chk("reset_runs", int'(RUNS), 0);
        RESET = 1'b0; tmr_nrst = 1'b1;
        repeat (2) @(negedge CLK);
        chk_idle_outs("idle_after_reset");

        foreach (vecs[i]) job(vecs[i].cyc, vecs[i].abort_run);

        // watchdog: timer never reports ready
        ready_low = 1'b1;
        e.done_cyc = 1 + TIMEOUT; e.runs = 0; e.starts = 1;
        sbq.push_back(e);
        start_go(2);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (k > 0) @(negedge CLK);
            if (ERR) begin
                seen = 1'b1;
                g = sbq.pop_front();
                chk("fault_cycle", k, g.done_cyc);
                chk("fault_runs", int'(RUNS), g.runs);
            end
        end
        if (!seen) begin
            chk("fault_timeout", 0, 1);
            if (sbq.size() > 0) g = sbq.pop_front();
        end
        repeat (3) begin
            @(negedge CLK);
            chk("fault_held", {ERR, TMR_CLEAR, BUSY, TMR_START, DONE}, 5'b11100);
        end
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        chk_idle_outs("after_clr_err");
        chk("runs_after_fault", int'(RUNS), 0);
        ready_low = 1'b0;
        job(1, 0);

        // reset in the middle of the second WAIT
        start_go(3);
        starts = 0; last = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (k > 0) @(negedge CLK);
            if (TMR_START) begin starts++; last = k; end
            if (starts == 2 && k == last + 3) seen = 1'b1;
        end
        chk("reach_2nd_wait", int'(seen), 1);
        RESET = 1'b1; tmr_nrst = 1'b0;
        #1;
        chk_idle_outs("mid_reset");
        chk("mid_reset_runs", int'(RUNS), 0);
        repeat (3) begin
            @(negedge CLK);
            chk("no_done_in_reset", int'(DONE), 0);
        end
        RESET = 1'b0; tmr_nrst = 1'b1;
        @(negedge CLK);
        chk_idle_outs("after_mid_reset");
        job(3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_sequencer.md
FSM_SEQUENCER -- requirements
Module: fsm_sequencer

Interface
REQ-001 Parameter N, default 256, period of the downstream fsm_timer; it SHALL equal that timer's N.
REQ-002 Parameter RUNS_W, default 4, width of the run-count input and output.
REQ-003 Parameter TIMEOUT, default N+8, the maximum number of WAIT cycles allowed before a fault.
REQ-004 CLK  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 GO  in  1  host request; sampled only in IDLE.
REQ-007 CYCLES  in  RUNS_W  number of timer runs requested; captured when GO is accepted.
REQ-008 ABORT  in  1  host request to stop after the current run; sampled in ARM and WAIT.
REQ-009 CLR_ERR  in  1  host acknowledge that clears a fault.
REQ-010 TMR_READY  in  1  connects to the READY output of fsm_timer.
REQ-011 TMR_START  out  1  connects to the START input of fsm_timer.
REQ-012 TMR_CLEAR  out  1  connects to the RESET input of fsm_timer.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 DONE  out  1  one-cycle completion pulse.
REQ-015 ERR  out  1  high while in FAULT.
REQ-016 RUNS  out  RUNS_W  number of completed runs in the current or most recent job.

Function
REQ-017 States SHALL be IDLE, ARM, WAIT, CLEAR, FINISH and FAULT; all outputs SHALL be Moore (decoded from registered state only).
REQ-018 IDLE: when GO=1 and CYCLES!=0, the block SHALL capture CYCLES as the target, clear RUNS and the abort flag, and go to ARM.
REQ-019 IDLE: when GO=1 and CYCLES=0, the block SHALL clear RUNS and go to FINISH without asserting TMR_START.
REQ-020 ARM: TMR_START=1 for exactly this one cycle, then go to WAIT unconditionally.
REQ-021 WAIT: a RUNS_W-independent wait counter SHALL start at 0 on entry and increment each cycle; width is clog2(TIMEOUT+1).
REQ-022 WAIT: when TMR_READY=1, go to CLEAR; this takes priority over timeout in the same cycle.
REQ-023 WAIT: when TMR_READY=0 and the wait counter equals TIMEOUT-1, go to FAULT.
REQ-024 CLEAR: TMR_CLEAR=1 for exactly one cycle and RUNS SHALL increment by 1, saturating at all-ones.
REQ-025 CLEAR: if RUNS+1 equals the target or the abort flag is set, go to FINISH; otherwise go to ARM.
REQ-026 ABORT=1 in ARM or WAIT SHALL set a sticky abort flag; the current run SHALL complete normally.
REQ-027 FINISH: DONE=1 for one cycle, then go to IDLE; GO is ignored in FINISH.
REQ-028 FAULT: ERR=1 and TMR_CLEAR=1 continuously; stay in FAULT until CLR_ERR=1, then go to IDLE; RUNS SHALL hold its value.
REQ-029 Timing with a matching timer: each run SHALL be exactly N+1 cycles (ARM 1 + WAIT N-1 + CLEAR 1), with TMR_READY first seen on the (N-1)th WAIT cycle.
REQ-030 RUNS SHALL hold its final value in IDLE until the next GO is accepted.

Reset
REQ-031 RESET=1 SHALL immediately force IDLE with RUNS=0, the target cleared, the abort flag cleared and the wait counter cleared.
REQ-032 During reset, TMR_START=0, TMR_CLEAR=0, BUSY=0, DONE=0 and ERR=0.
REQ-033 Reset asserted mid-job SHALL abandon the job with no DONE pulse; the downstream timer is reset separately by its own N_RESET.

Structure
REQ-034 The state enumeration seq_state_t SHALL live in package fsm_seq_pkg, together with the default-N constant shared with fsm_timer.
REQ-035 The design SHALL be a single module with no sub-modules; the testbench SHALL instantiate fsm_timer as the downstream load.

Verification
REQ-036 N=8, CYCLES=3, GO pulsed once -> TMR_START pulses at 0, 9 and 18 cycles after the accept edge; DONE one cycle wide at cycle 27; RUNS=3; BUSY low at cycle 28.
REQ-037 N=8, CYCLES=0, GO -> DONE on the cycle after acceptance; TMR_START never asserted; RUNS=0.
REQ-038 N=8, CYCLES=5, ABORT pulsed during the 2nd WAIT -> exactly 2 runs complete; DONE asserted; RUNS=2.
REQ-039 TMR_READY tied to 0, TIMEOUT=16 -> FAULT after 16 WAIT cycles with ERR=1 and TMR_CLEAR=1 held; CLR_ERR -> IDLE; the next GO is accepted.
REQ-040 RESET asserted during the 2nd WAIT -> all outputs 0 immediately; no DONE pulse; GO after release starts a fresh job with RUNS=0.
REQ-041 CYCLES=15 (all ones, RUNS_W=4) -> 15 runs complete; RUNS=15; no wrap occurs.
